seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexes NUM_DIGITS 4-bit digit values onto one shared 7-seg decoder.
//  Sits directly upstream of the 4-bit-to-segment decoder and drives its number/reset inputs.
//  Drives the active-low digit anodes with an inter-digit dead time to prevent ghosting.
//  Double-buffers the digit values so a display update never tears mid-frame.
// PARAMETERS
//  NUM_DIGITS   4       digits scanned per frame (>=2)
//  TICK_DIV     100000  clk cycles per digit slot (>= DEAD_CYCLES+2)
//  DEAD_CYCLES  1000    cycles at slot start with all anodes off (>=1)
// PORTS
//  clk           in   1             system clock
//  reset         in   1             synchronous, active-low reset
//  digit_values  in   4*NUM_DIGITS  digit k = bits [4k+3:4k]; digit 0 = rightmost
//  digit_blank   in   NUM_DIGITS    1 = keep digit k dark; captured together with digit_values
//  load          in   1             1-cycle strobe: capture digit_values/digit_blank into pending
//  number        out  4             value for current slot -> decoder number input
//  blank         out  1             1 = decoder shows its blank/reset pattern -> decoder reset input
//  anode         out  NUM_DIGITS    active-low digit enables; at most one bit low at any time
//  frame_done    out  1             1-cycle pulse on the first cycle of each new frame (slot 0)
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): anode all 1s, number=0, blank=1, frame_done=0.
//    Internals: cnt=0, idx=0, pending=active=0, blank masks=all 1s, pend_valid=0.
//  - Reset mid-frame: all state returns to the reset values on the same edge.
//  - Prescaler: cnt counts 0..TICK_DIV-1, then wraps to 0.
//    idx advances on each wrap: 0..NUM_DIGITS-1, then back to 0.
//  - Slot timing: a slot is TICK_DIV cycles. Outputs are registered.
//    number/blank change on the first cycle of the slot.
//    anode[idx] goes low after DEAD_CYCLES cycles and stays low for TICK_DIV-DEAD_CYCLES cycles.
//    All other anodes stay 1.
//  - After reset release: the first cycle is slot 0, cycle 0.
//  - Blanked digit: if active_blank[idx]==1, then blank=1, number=0, and anode stays all 1s
//    for the whole slot. Scan timing is unchanged.
//  - load=1: digit_values/digit_blank are copied into pending, pend_valid<=1.
//    A later load before transfer overwrites pending; last load wins.
//  - Frame boundary (idx wraps NUM_DIGITS-1 -> 0):
//    if pend_valid, then active<=pending and pend_valid<=0.
//    frame_done=1 during cycle 0 of slot 0 only.
//  - Simultaneous load and boundary: the newly presented values go straight into active and
//    are used for the new frame; pend_valid ends 0.
//  - active never changes except at a frame boundary. No handshake back-pressure; load is
//    never dropped.
//  - Widths: cnt is $clog2(TICK_DIV) bits; idx is $clog2(NUM_DIGITS) bits.
//    No arithmetic is done on digit values; codes 10-15 pass through to the decoder unchanged.
// STRUCTURE
//  - Shared package seg_pkg:
//    DIGIT_W=4, ANODE_OFF=1'b1, SEG_BLANK=7'b1111110.
//    Function digit_slice(vec,k).
//  - One sub-module, seg_tick_gen:
//    parameter TICK_DIV; inputs clk, reset; outputs cnt and wrap pulse.
//    The scan/buffer logic stays in this module.
// TESTING  (bench params: NUM_DIGITS=4, TICK_DIV=8, DEAD_CYCLES=2)
//  1. Hold reset low for 3 cycles
//     -> anode=4'b1111, blank=1, number=0, frame_done=0 on every cycle.
//  2. Release reset; load 16'h4321, blank=0; let the first frame (all digits blank) complete
//     -> frame_done pulses every 32 cycles.
//     -> From the next frame: number sequence 1,2,3,4, each held 8 cycles.
//     -> anode=1110 for cycles 2-7 of slot 0, 1101 for slot 1, and so on; 1111 on slot cycles 0-1.
//  3. Mid-frame, load 16'h9999 while digit 2 is shown
//     -> remaining slots of that frame still show 3,4.
//     -> 9s appear only from the next frame_done.
//  4. Assert load on the wrap cycle (idx=3, cnt=7) with 16'h0005
//     -> the new frame shows 5,0,0,0 immediately; pend_valid=0 afterwards.
//  5. Set digit_blank=4'b0100 and load
//     -> in slot 2: anode=1111 for all 8 cycles, blank=1; other digits are unaffected.
//  6. Pull reset low at cnt=5 of slot 1
//     -> next edge: anode=1111, idx=0, cnt=0, active cleared.
//     -> After release, all digits stay dark until a new load.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
package seg_pkg;

    localparam int          DIGIT_W    = 4;
    localparam int          MAX_DIGITS = 16;
    localparam int          SLICE_W    = DIGIT_W * MAX_DIGITS;
    localparam logic        ANODE_OFF  = 1'b1;
    localparam logic [6:0]  SEG_BLANK  = 7'b1111110;

    typedef enum logic {
        PH_DEAD  = 1'b0,
        PH_DRIVE = 1'b1
    } slot_phase_e;

    // Caller zero-extends its packed digit vector to SLICE_W bits.
    function automatic logic [DIGIT_W-1:0] digit_slice(input logic [SLICE_W-1:0] vec,
                                                       input int k);
        return vec[k*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Digit-slot prescaler: free-running 0..TICK_DIV-1 counter with a last-cycle flag.
module seg_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [$clog2(TICK_DIV)-1:0] cnt_o,
    output logic                        wrap_o
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign wrap_o = (cnt_q == LAST_CNT);
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans double-buffered digit values onto one shared decoder with per-slot anode dead time.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digit_values,
    input  logic [NUM_DIGITS-1:0]         digit_blank,
    input  logic                          load,
    output logic [DIGIT_W-1:0]            number,
    output logic                          blank,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic                          frame_done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = DIGIT_W * NUM_DIGITS;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] DRIVE_FROM = CW'(DEAD_CYCLES - 1);

    logic [CW-1:0]         cnt;
    logic                  wrap;
    logic                  frameEnd;
    slot_phase_e           phase_d;

    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         pendVals_q, pendVals_d;
    logic [NUM_DIGITS-1:0] pendBlank_q, pendBlank_d;
    logic                  pendValid_q, pendValid_d;
    logic [VW-1:0]         activeVals_q, activeVals_d;
    logic [NUM_DIGITS-1:0] activeBlank_q, activeBlank_d;

    logic [DIGIT_W-1:0]    number_q, number_d;
    logic                  blank_q, blank_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frameDone_q;

    seg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .cnt_o  (cnt),
        .wrap_o (wrap)
    );

    // Outputs are derived from next-cycle state so they line up with cnt/idx on the same cycle.
    always_comb begin
        frameEnd      = wrap && (idx_q == LAST_IDX);
        idx_d         = idx_q;
        pendVals_d    = pendVals_q;
        pendBlank_d   = pendBlank_q;
        pendValid_d   = pendValid_q;
        activeVals_d  = activeVals_q;
        activeBlank_d = activeBlank_q;

        if (wrap) begin
            idx_d = frameEnd ? '0 : idx_q + 1'b1;
        end

        if (frameEnd) begin
            if (load) begin
                activeVals_d  = digit_values;
                activeBlank_d = digit_blank;
            end else if (pendValid_q) begin
                activeVals_d  = pendVals_q;
                activeBlank_d = pendBlank_q;
            end
            pendValid_d = 1'b0;
        end else if (load) begin
            pendVals_d  = digit_values;
            pendBlank_d = digit_blank;
            pendValid_d = 1'b1;
        end

        phase_d  = (!wrap && (cnt >= DRIVE_FROM)) ? PH_DRIVE : PH_DEAD;
        blank_d  = activeBlank_d[idx_d];
        number_d = blank_d ? '0 : digit_slice(SLICE_W'(activeVals_d), int'(idx_d));
        if (blank_d || (phase_d == PH_DEAD)) begin
            anode_d = {NUM_DIGITS{ANODE_OFF}};
        end else begin
            anode_d = ~(NUM_DIGITS'(1) << idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q         <= '0;
            pendVals_q    <= '0;
            pendBlank_q   <= '1;
            pendValid_q   <= 1'b0;
            activeVals_q  <= '0;
            activeBlank_q <= '1;
            number_q      <= '0;
            blank_q       <= 1'b1;
            anode_q       <= {NUM_DIGITS{ANODE_OFF}};
            frameDone_q   <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pendVals_q    <= pendVals_d;
            pendBlank_q   <= pendBlank_d;
            pendValid_q   <= pendValid_d;
            activeVals_q  <= activeVals_d;
            activeBlank_q <= activeBlank_d;
            number_q      <= number_d;
            blank_q       <= blank_d;
            anode_q       <= anode_d;
            frameDone_q   <= frameEnd;
        end
    end

    assign number     = number_q;
    assign blank      = blank_q;
    assign anode      = anode_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed slot-by-slot check of seg_scan_driver with NUM_DIGITS=4, TICK_DIV=8, DEAD_CYCLES=2.
module tb_seg_scan_driver;

    localparam int ND   = 4;
    localparam int TD   = 8;
    localparam int DEAD = 2;

    logic        clk;
    logic        reset;
    logic [15:0] digit_values;
    logic [3:0]  digit_blank;
    logic        load;
    logic [3:0]  number;
    logic        blank;
    logic [3:0]  anode;
    logic        frame_done;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int          ldCycle;
        logic [15:0] vals;
        logic [3:0]  blanks;
        logic [3:0]  num;
        logic        blk;
        logic        fd;
    } slotVec_t;

    slotVec_t vecs[$];

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (TD),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digit_values (digit_values),
        .digit_blank  (digit_blank),
        .load         (load),
        .number       (number),
        .blank        (blank),
        .anode        (anode),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] b);
        load = ld;
        if (ld) begin
            digit_values = v;
            digit_blank  = b;
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expNum, input logic expBlk,
                               input logic [3:0] expAnode, input logic expFd);
        testsRun++;
        if (number !== expNum || blank !== expBlk || anode !== expAnode || frame_done !== expFd) begin
            testsFailed++;
            $display("[TB] FAIL %s: got number=%0h blank=%b anode=%b frame_done=%b, expected number=%0h blank=%b anode=%b frame_done=%b",
                     name, number, blank, anode, frame_done, expNum, expBlk, expAnode, expFd);
        end
    endtask

    // Entered at the falling edge of cycle 0 of a slot; leaves at the falling edge after ncycles.
    task automatic runSlot(input string tag, input int idx, input int ncycles, input slotVec_t v);
        logic [3:0] expAnode;
        for (int c = 0; c < ncycles; c++) begin
            expAnode = (c < DEAD || v.blk) ? 4'b1111 : ~(4'b0001 << idx);
            checkOutput($sformatf("%s.slot%0d.c%0d", tag, idx, c), v.num, v.blk, expAnode,
                        v.fd && (c == 0));
            applyStimulus(c == v.ldCycle, v.vals, v.blanks);
            @(negedge clk);
        end
    endtask

    function automatic slotVec_t sv(input int ld, input logic [15:0] vl, input logic [3:0] bl,
                                    input logic [3:0] n, input logic bk, input logic f);
        slotVec_t r;
        r.ldCycle = ld; r.vals = vl; r.blanks = bl; r.num = n; r.blk = bk; r.fd = f;
        return r;
    endfunction

    initial begin
        reset        = 1'b0;
        load         = 1'b0;
        digit_values = '0;
        digit_blank  = '0;

        // Frame 0: nothing loaded yet, so every slot is dark; load 4321 on the first cycle.
        vecs.push_back(sv( 0, 16'h4321, 4'h0, 4'h0, 1'b1, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b1, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b1, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b1, 1'b0));
        // Frame 1: 4321 now active.
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h1, 1'b0, 1'b1));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h2, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h3, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h4, 1'b0, 1'b0));
        // Frame 2: mid-frame load of 9999 must not tear the rest of this frame.
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h1, 1'b0, 1'b1));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h2, 1'b0, 1'b0));
        vecs.push_back(sv( 3, 16'h9999, 4'h0, 4'h3, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h4, 1'b0, 1'b0));
        // Frame 3: 9s; load 0005 on the very last cycle of the frame.
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h9, 1'b0, 1'b1));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h9, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h9, 1'b0, 1'b0));
        vecs.push_back(sv( 7, 16'h0005, 4'h0, 4'h9, 1'b0, 1'b0));
        // Frames 4 and 5: 0005 used at once and not replaced by stale pending data.
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h5, 1'b0, 1'b1));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h5, 1'b0, 1'b1));
        vecs.push_back(sv( 4, 16'h8765, 4'h4, 4'h0, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b0, 1'b0));
        // Frame 6: digit 2 masked dark, others unaffected.
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h5, 1'b0, 1'b1));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h6, 1'b0, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h0, 1'b1, 1'b0));
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h8, 1'b0, 1'b0));
        // Frame 7, slot 0.
        vecs.push_back(sv(-1, 16'h0,    4'h0, 4'h5, 1'b0, 1'b1));

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset.c%0d", i), 4'h0, 1'b1, 4'b1111, 1'b0);
        end
        reset = 1'b1;

        foreach (vecs[i]) begin
            runSlot($sformatf("v%0d", i), i % ND, TD, vecs[i]);
        end

        // Reset pulled low at cnt=5 of slot 1 while 6 is being shown.
        runSlot("midrst", 1, 5, sv(-1, 16'h0, 4'h0, 4'h6, 1'b0, 1'b0));
        checkOutput("midrst.slot1.c5", 4'h6, 1'b0, 4'b1101, 1'b0);
        applyStimulus(1'b0, 16'h0, 4'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst.resetEdge", 4'h0, 1'b1, 4'b1111, 1'b0);
        reset = 1'b1;

        // Active buffer was cleared: two dark frames, then a fresh load shows up aligned to slot 0.
        for (int s = 0; s < ND; s++) begin
            runSlot("postA", s, TD, sv(-1, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0));
        end
        runSlot("postB", 0, TD, sv(3, 16'h1234, 4'h0, 4'h0, 1'b1, 1'b1));
        for (int s = 1; s < ND; s++) begin
            runSlot("postB", s, TD, sv(-1, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0));
        end
        runSlot("postC", 0, TD, sv(-1, 16'h0, 4'h0, 4'h4, 1'b0, 1'b1));
        runSlot("postC", 1, TD, sv(-1, 16'h0, 4'h0, 4'h3, 1'b0, 1'b0));
        runSlot("postC", 2, TD, sv(-1, 16'h0, 4'h0, 4'h2, 1'b0, 1'b0));
        runSlot("postC", 3, TD, sv(-1, 16'h0, 4'h0, 4'h1, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
